// File: rtl/mfp_ahb_sevensegscan.sv
// Eight-digit seven-segment scan controller: walks the digits one slot at a time,
// with per-frame input snapshots, a dark guard interval at slot start and blink support.
module mfp_ahb_sevensegscan #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 256,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  EN,
  input  logic [39:0] DIGITS,
  input  logic [7:0]  DP,
  input  logic [7:0]  BLINK,
  output logic [7:0]  AN,
  output logic [5:0]  DISP_DATA,
  output logic        FRAME_TICK
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [7:0]    en_s_q, en_s_d;
  logic [39:0]   digits_s_q, digits_s_d;
  logic [7:0]    dp_s_q, dp_s_d;
  logic [7:0]    blink_s_q, blink_s_d;
  logic [7:0]    an_q, an_d;
  logic [5:0]    disp_q, disp_d;
  logic          tick_q, tick_d;
  logic          slot_wrap, frame_end, lit_d, past_guard;
  logic [4:0]    code_d [8];

  // Counters and shadows; shadows only move on the frame-end cycle so a frame is never torn.
  always_comb begin
    slot_wrap  = (slot_q == SLOT_LAST);
    frame_end  = slot_wrap && (idx_q == 3'd7);
    slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d      = slot_wrap ? idx_q + 3'd1 : idx_q;
    en_s_d     = en_s_q;
    digits_s_d = digits_s_q;
    dp_s_d     = dp_s_q;
    blink_s_d  = blink_s_q;
    frame_d    = frame_q;
    phase_d    = phase_q;
    if (frame_end) begin
      en_s_d     = EN;
      digits_s_d = DIGITS;
      dp_s_d     = DP;
      blink_s_d  = BLINK;
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_code
    assign code_d[gi] = digits_s_d[5*gi +: 5];
  end

  if (GUARD == 0) begin : g_noguard
    assign past_guard = 1'b1;
  end else begin : g_guard
    localparam logic [SW-1:0] GUARD_C = SW'(GUARD);
    assign past_guard = (slot_d >= GUARD_C);
  end

  // Outputs are computed from next-state values so the registered copy lines up with the counters.
  always_comb begin
    lit_d  = en_s_d[idx_d] & ~(blink_s_d[idx_d] & phase_d);
    an_d   = (lit_d && past_guard) ? ~(8'h01 << idx_d) : 8'hFF;
    disp_d = lit_d ? {~dp_s_d[idx_d], code_d[idx_d]} : 6'h3F;
    tick_d = (idx_d == 3'd7) && (slot_d == SLOT_LAST);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      slot_q     <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      phase_q    <= 1'b0;
      en_s_q     <= '0;
      digits_s_q <= '0;
      dp_s_q     <= '0;
      blink_s_q  <= '0;
      an_q       <= 8'hFF;
      disp_q     <= 6'h3F;
      tick_q     <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      en_s_q     <= en_s_d;
      digits_s_q <= digits_s_d;
      dp_s_q     <= dp_s_d;
      blink_s_q  <= blink_s_d;
      an_q       <= an_d;
      disp_q     <= disp_d;
      tick_q     <= tick_d;
    end
  end

  assign AN         = an_q;
  assign DISP_DATA  = disp_q;
  assign FRAME_TICK = tick_q;

endmodule

// File: doc/mfp_ahb_sevensegscan.md
# mfp_ahb_sevensegscan

Time-multiplexing scan controller for the 8-digit seven-segment display. It takes per-digit 5-bit display codes, decimal points, enable and blink masks, and cycles through the digits. For the active digit it drives the active-low anode strobes and the 6-bit `{dp_n, code}` word consumed by `mfp_ahb_sevensegdec`. Inputs are snapshotted once per frame so the display never shows a torn update; a guard interval at the start of each digit slot suppresses ghosting.

## Interface
- `SCAN_DIV`, 50000, clocks per digit slot (≥ `GUARD`+2)
- `GUARD`, 256, clocks at slot start with all anodes off (≥ 0)
- `BLINK_FRAMES`, 64, frames per blink-phase toggle (≥ 1)

- `HCLK`  in  1  clock
- `HRESETn`  in  1  reset, asynchronous, active-low
- `EN`  in  8  digit enable, 1 = digit may light
- `DIGITS`  in  40  digit i code = `DIGITS[5i+4:5i]`, decoder code space 0–31 (31 = blank)
- `DP`  in  8  decimal point, 1 = lit
- `BLINK`  in  8  blink mask, 1 = digit dark during blink phase 1
- `AN`  out  8  anode strobes, active-low, at most one bit low
- `DISP_DATA`  out  6  to decoder: `[5]` = ~dp (active-low dp), `[4:0]` = code
- `FRAME_TICK`  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- `slot_cnt` counts 0..`SCAN_DIV`-1 and wraps. On wrap, `idx` (0..7) increments, wrapping 7→0. One frame = 8·`SCAN_DIV` clocks.
- Shadow registers `EN_s`, `DIGITS_s`, `DP_s`, `BLINK_s` load from the inputs on the frame-end cycle (`idx`==7, `slot_cnt`==`SCAN_DIV`-1) and are used for the whole following frame. Input changes mid-frame have no visible effect until the next frame.
- `frame_cnt` counts frame-ends 0..`BLINK_FRAMES`-1. On its wrap, `blink_phase` toggles.
- `lit(k)` = `EN_s[k]` & ~(`BLINK_s[k]` & `blink_phase`).
- Outputs are registered and aligned to the counters: in the cycle where (`idx`,`slot_cnt`) = (k,c):
  - `AN` = ~(1<<k) if `lit(k)` and c ≥ `GUARD`, else 8'hFF.
  - `DISP_DATA` = {~`DP_s[k]`, `DIGITS_s[5k+4:5k]`} if `lit(k)`, else 6'h3F (dp off, blank code 31). The value is constant over the slot, including the guard interval.
  - `FRAME_TICK` = 1 iff k==7 and c==`SCAN_DIV`-1.
- With `GUARD`=0, anodes are on for the full slot.

## Timing
- Reset (async assert, sync release on next `HCLK`): `slot_cnt`=0, `idx`=0, `frame_cnt`=0, `blink_phase`=0, all shadows 0, `AN`=8'hFF, `DISP_DATA`=6'h3F, `FRAME_TICK`=0.
- After reset the first frame is dark because `EN_s`=0. The first snapshot is taken at cycle 8·`SCAN_DIV`-1 after release; digits first light in slot 0 of frame 2 at `slot_cnt`==`GUARD`.
- Snapshot, blink toggle and `FRAME_TICK` all occur on the same frame-end cycle. The new shadow values and the new `blink_phase` govern from the next cycle (frame slot 0).
- Reset mid-slot: outputs go to reset values immediately (asynchronous), without waiting for a clock edge. The scan restarts from digit 0 with a dark frame.
- No output glitches: `AN` changes only at slot start (→FF) and at `slot_cnt`==`GUARD`. Two anodes are never low in the same cycle.

## Test plan
Params `SCAN_DIV`=8, `GUARD`=2, `BLINK_FRAMES`=2.
- Reset: `HRESETn`=0 → `AN`=FF, `DISP_DATA`=3F, `FRAME_TICK`=0. After release with `EN`=FF: `AN`=FF for cycles 0–63, `FRAME_TICK`=1 only at cycle 63.
- Scan: `EN`=FF, digit i code = i, `DP`=0 → in frame 2, slot k cycles 0–1 `AN`=FF, cycles 2–7 `AN`=~(1<<k), `DISP_DATA`={1,k}. `FRAME_TICK` at cycle 127.
- Tear-free update: change digit 2 code 2→9 during slot 1 of frame 2 → slot 2 of frame 2 still shows 2; slot 2 of frame 3 shows 9.
- Masking/dp: `EN`=08, `DP`=08, digit 3 code=5 → slot 3 `DISP_DATA`=6'h05 and `AN`=F7 on cycles 2–7. All other slots: `DISP_DATA`=3F, `AN`=FF.
- Blink: `EN`=FF, `BLINK`=01 → digit 0 lit in frames where `blink_phase`=0, dark (`AN`=FF, `DISP_DATA`=3F) in frames where `blink_phase`=1. The phase toggles every 2 frames; other digits stay unaffected.
- Mid-operation reset: assert `HRESETn` in slot 4 cycle 5 → `AN`=FF same cycle. After release, digit 0 scan restarts and the first frame is dark.
